// File: rtl/array_mult4.sv
// array_mult4: 4x4 unsigned array multiplier with a registered product.
// The combinational core is an AND-gate partial-product array summed by three
// rows of half/full adder cells; a single register stage follows.

// Half adder cell: used wherever the carry-in would be a constant zero.
module array_mult4_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// Full adder cell.
module array_mult4_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ ci;
  assign c = (x & y) | (x & ci) | (y & ci);
endmodule

module array_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p,
  output logic       out_valid
);

  // pp[i][j] = a[j] & b[i]
  logic [3:0] pp [4];

  // Per-row adder signals for rows 1..3. row_upper is the shifted running
  // sum entering the row; row_carry[k][j] is the carry out of cell j.
  logic [3:0] row_upper [1:3];
  logic [3:0] row_sum   [1:3];
  logic [3:0] row_carry [1:3];

  logic [7:0] p_comb;

  // Partial-product AND array.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp[i] = a & {4{b[i]}};
    end
  end

  // The running sum entering each row drops its LSB (already a product bit)
  // and takes the previous row's final carry as its new MSB. Row 0 has no
  // carry, so row 1 sees a zero in the top position.
  assign row_upper[1] = {1'b0, pp[0][3:1]};
  assign row_upper[2] = {row_carry[1][3], row_sum[1][3:1]};
  assign row_upper[3] = {row_carry[2][3], row_sum[2][3:1]};

  genvar k, j;
  generate
    for (k = 1; k <= 3; k++) begin : g_row
      // Cell 0 of every row has no incoming carry: half adder.
      array_mult4_ha u_ha (
        .x (pp[k][0]),
        .y (row_upper[k][0]),
        .s (row_sum[k][0]),
        .c (row_carry[k][0])
      );
      for (j = 1; j < 4; j++) begin : g_cell
        array_mult4_fa u_fa (
          .x  (pp[k][j]),
          .y  (row_upper[k][j]),
          .ci (row_carry[k][j-1]),
          .s  (row_sum[k][j]),
          .c  (row_carry[k][j])
        );
      end
    end
  endgenerate

  // LSB of each row is a finished product bit; the last row supplies the top.
  assign p_comb = {row_carry[3][3], row_sum[3][3:1],
                   row_sum[3][0], row_sum[2][0], row_sum[1][0], pp[0][0]};

  // Output register: capture on in_valid, otherwise hold p and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        p <= p_comb;
      end
    end
  end

endmodule

// File: tb/tb_array_mult4.sv
// Directed testbench for array_mult4: reset, small values, carry stress,
// hold, zero operands and an exhaustive back-to-back sweep.
module tb_array_mult4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] p;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  array_mult4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .p         (p),
    .out_valid (out_valid)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge
  // capture, then sample outputs 1 unit later.
  task automatic step(input logic v, input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic mul(input string tag, input logic [3:0] av, input logic [3:0] bv,
                     input logic [7:0] exp);
    step(1'b1, av, bv);
    check({tag, "_p"}, p, exp);
    check({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;
    #12;
    check("reset_p", p, 8'd0);
    check("reset_ov", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity and small values
    mul("m1x1", 4'd1, 4'd1, 8'd1);
    mul("m2x1", 4'd2, 4'd1, 8'd2);
    mul("m3x1", 4'd3, 4'd1, 8'd3);
    mul("m4x1", 4'd4, 4'd1, 8'd4);
    mul("m6x2", 4'd6, 4'd2, 8'd12);

    // Carry stress, back-to-back
    mul("m13x15", 4'd13, 4'd15, 8'd195);
    mul("m10x9", 4'd10, 4'd9, 8'd90);
    mul("m5x9", 4'd5, 4'd9, 8'd45);
    mul("m8x13", 4'd8, 4'd13, 8'd104);
    mul("m15x15", 4'd15, 4'd15, 8'd225);

    // Hold: in_valid low, operands change, p must not move
    step(1'b0, 4'd0, 4'd7);
    check("hold_p", p, 8'd225);
    check("hold_ov", {7'd0, out_valid}, 8'd0);
    step(1'b0, 4'bxxxx, 4'bxxxx);
    check("hold_x_p", p, 8'd225);
    check("hold_x_ov", {7'd0, out_valid}, 8'd0);

    // Zero operands
    mul("m0x9", 4'd0, 4'd9, 8'd0);
    mul("m12x0", 4'd12, 4'd0, 8'd0);

    // Reset mid-cycle with p nonzero; operands offered during reset are dropped
    mul("pre_rst", 4'd7, 4'd11, 8'd77);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd9;
    b        = 4'd9;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_p", p, 8'd0);
    check("midrst_ov", {7'd0, out_valid}, 8'd0);
    @(posedge clk);
    #1;
    check("inrst_p", p, 8'd0);
    check("inrst_ov", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 4'd5, 4'd5);
    check("postrst_idle_p", p, 8'd0);
    check("postrst_idle_ov", {7'd0, out_valid}, 8'd0);
    step(1'b0, 4'd3, 4'd3);
    check("postrst_idle2_p", p, 8'd0);

    // Exhaustive sweep, streamed with in_valid held high
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ia;
      logic [3:0] ib;
      logic [7:0] exp;
      ia  = i[7:4];
      ib  = i[3:0];
      exp = 8'(ia) * 8'(ib);
      step(1'b1, ia, ib);
      check($sformatf("ex_%0dx%0d", ia, ib), p, exp);
      check("ex_ov", {7'd0, out_valid}, 8'd1);
    end
    step(1'b0, 4'd0, 4'd0);
    check("end_hold_p", p, 8'd225);
    check("end_ov", {7'd0, out_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
